// File: rtl/dm_arb_pkg.sv
// dm_arb_pkg: shared definitions for the dm_arbiter slice.
//   - default byte-address and data widths of the `dm` data memory
//   - arbiter state encoding
//   - port identifiers (port 0 = CPU load/store unit, port 1 = DMA/debug loader)
package dm_arb_pkg;

  localparam int DM_AW = 10;
  localparam int DM_DW = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

endpackage

// File: rtl/dm_arbiter_rr_arb2.sv
// rr_arb2: combinational two-requester picker.
//   elig_i        eligible requesters, bit N = port N
//   ptr_i         round-robin pointer: port that wins a tie
//   grant_valid_o at least one requester is eligible
//   grant_id_o    winning port (don't-care when grant_valid_o is low)
// FIXED_PRIO != 0 ignores the pointer and always favours port 0.
module rr_arb2
  import dm_arb_pkg::*;
#(
  parameter int FIXED_PRIO = 0
) (
  input  logic [1:0] elig_i,
  input  logic       ptr_i,
  output logic       grant_valid_o,
  output logic       grant_id_o
);

  always_comb begin
    grant_valid_o = |elig_i;
    grant_id_o    = PORT_CPU;
    if (FIXED_PRIO != 0) begin
      grant_id_o = elig_i[PORT_CPU] ? PORT_CPU : PORT_DMA;
    end else if (elig_i[ptr_i]) begin
      grant_id_o = ptr_i;
    end else begin
      grant_id_o = ~ptr_i;
    end
  end

endmodule

// File: rtl/dm_arbiter.sv
// dm_arbiter: two-port arbiter/sequencer in front of the single-port data
// memory `dm` (byte address, 32-bit little-endian word, combinational read).
//   clk, reset              clock; synchronous active-high reset
//   reqN/weN/addrN/wdataN   port N request (held until ackN), direction,
//                           word-aligned byte address, write data
//   ackN/errN/rdataN        one-cycle completion pulse, misaligned flag,
//                           read word (0 for writes and errors)
//   busy                    arbiter is not idle
//   dm_addr/dm_din/dm_we    memory address, write data, write enable
//   dm_dout                 combinational memory read data
// Each granted access takes IDLE -> ACCESS -> RESP (ack two cycles after the
// grant); misaligned requests skip ACCESS and are acked one cycle after grant.
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int AW         = DM_AW,
  parameter int DW         = DM_DW,
  parameter int FIXED_PRIO = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          ack0,
  output logic          ack1,
  output logic          err0,
  output logic          err1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          busy,
  output logic [AW-1:0] dm_addr,
  output logic [DW-1:0] dm_din,
  output logic          dm_we,
  input  logic [DW-1:0] dm_dout
);

  state_e             state_q, state_d;
  logic               ptr_q, ptr_d;
  logic               win_q, win_d;
  logic               err_q, err_d;
  logic               we_q, we_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic [DW-1:0]      wdata_q, wdata_d;
  logic [1:0][DW-1:0] rdata_q, rdata_d;

  logic [1:0]         req_v, we_v, ack_v, err_v, elig;
  logic [1:0][AW-1:0] addr_v;
  logic [1:0][DW-1:0] wdata_v;
  logic               grant_valid, grant_id;

  assign req_v   = {req1, req0};
  assign we_v    = {we1, we0};
  assign addr_v  = {addr1, addr0};
  assign wdata_v = {wdata1, wdata0};

  // Ack/err are decoded from the RESP state so they are high for exactly
  // that one cycle and only on the port that won.
  for (genvar gi = 0; gi < 2; gi++) begin : g_resp
    assign ack_v[gi] = (state_q == RESP) && (win_q == 1'(gi));
    assign err_v[gi] = ack_v[gi] && err_q;
  end

  // A port whose ack is high this cycle is finishing, not asking again.
  assign elig = req_v & ~ack_v;

  rr_arb2 #(
    .FIXED_PRIO(FIXED_PRIO)
  ) u_pick (
    .elig_i       (elig),
    .ptr_i        (ptr_q),
    .grant_valid_o(grant_valid),
    .grant_id_o   (grant_id)
  );

  assign ack0   = ack_v[0];
  assign ack1   = ack_v[1];
  assign err0   = err_v[0];
  assign err1   = err_v[1];
  assign rdata0 = rdata_q[0];
  assign rdata1 = rdata_q[1];
  assign busy   = (state_q != IDLE);

  // The latched address/data only change on an aligned grant, so the memory
  // bus holds its last values outside ACCESS. The write enable is gated by
  // reset combinationally so a reset during ACCESS aborts the write.
  assign dm_addr = addr_q;
  assign dm_din  = wdata_q;
  assign dm_we   = (state_q == ACCESS) && we_q && !reset;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    err_d   = err_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          win_d = grant_id;
          if (addr_v[grant_id][1:0] != 2'b00) begin
            err_d            = 1'b1;
            rdata_d[grant_id] = '0;
            state_d          = RESP;
          end else begin
            we_d    = we_v[grant_id];
            addr_d  = addr_v[grant_id];
            wdata_d = wdata_v[grant_id];
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        rdata_d[win_q] = we_q ? '0 : dm_dout;
        state_d        = RESP;
      end
      RESP: begin
        if (FIXED_PRIO == 0) begin
          ptr_d = ~win_q;
        end
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= PORT_CPU;
      win_q   <= PORT_CPU;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      err_q   <= err_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: bench for dm_arbiter. A round-robin instance (dut) and a
// fixed-priority instance (dut_f) each sit in front of their own byte-array
// memory. A word-level reference memory predicts all read data.
module tb_dm_arbiter;
  import dm_arb_pkg::*;

  localparam int AW   = 10;
  localparam int DW   = 32;
  localparam int NRND = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic          req0, req1, we0, we1, ack0, ack1, err0, err1, busy, dm_we;
  logic [AW-1:0] addr0, addr1, dm_addr;
  logic [DW-1:0] wdata0, wdata1, rdata0, rdata1, dm_din, dm_dout;

  logic          req0_f, req1_f, we0_f, we1_f, ack0_f, ack1_f, err0_f, err1_f, busy_f, dm_we_f;
  logic [AW-1:0] addr0_f, addr1_f, dm_addr_f;
  logic [DW-1:0] wdata0_f, wdata1_f, rdata0_f, rdata1_f, dm_din_f, dm_dout_f;

  logic [7:0]  mem   [1024];
  logic [7:0]  mem_f [1024];
  logic [31:0] ref_mem [256];

  int vectors = 0;
  int miscompares = 0;

  dm_arbiter #(.AW(AW), .DW(DW), .FIXED_PRIO(0)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
    .rdata0(rdata0), .rdata1(rdata1), .busy(busy),
    .dm_addr(dm_addr), .dm_din(dm_din), .dm_we(dm_we), .dm_dout(dm_dout)
  );

  dm_arbiter #(.AW(AW), .DW(DW), .FIXED_PRIO(1)) dut_f (
    .clk(clk), .reset(reset),
    .req0(req0_f), .req1(req1_f), .we0(we0_f), .we1(we1_f),
    .addr0(addr0_f), .addr1(addr1_f), .wdata0(wdata0_f), .wdata1(wdata1_f),
    .ack0(ack0_f), .ack1(ack1_f), .err0(err0_f), .err1(err1_f),
    .rdata0(rdata0_f), .rdata1(rdata1_f), .busy(busy_f),
    .dm_addr(dm_addr_f), .dm_din(dm_din_f), .dm_we(dm_we_f), .dm_dout(dm_dout_f)
  );

  // Little-endian byte memories, write on posedge, combinational read.
  always @(posedge clk) begin
    if (dm_we) begin
      mem[dm_addr]         <= dm_din[7:0];
      mem[dm_addr + 10'd1] <= dm_din[15:8];
      mem[dm_addr + 10'd2] <= dm_din[23:16];
      mem[dm_addr + 10'd3] <= dm_din[31:24];
    end
    if (dm_we_f) begin
      mem_f[dm_addr_f]         <= dm_din_f[7:0];
      mem_f[dm_addr_f + 10'd1] <= dm_din_f[15:8];
      mem_f[dm_addr_f + 10'd2] <= dm_din_f[23:16];
      mem_f[dm_addr_f + 10'd3] <= dm_din_f[31:24];
    end
  end
  assign dm_dout   = {mem[dm_addr + 10'd3], mem[dm_addr + 10'd2],
                      mem[dm_addr + 10'd1], mem[dm_addr]};
  assign dm_dout_f = {mem_f[dm_addr_f + 10'd3], mem_f[dm_addr_f + 10'd2],
                      mem_f[dm_addr_f + 10'd1], mem_f[dm_addr_f]};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_port(input int p, input logic r, input logic w,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (p == 0) begin
      req0 = r; we0 = w; addr0 = a; wdata0 = d;
    end else begin
      req1 = r; we1 = w; addr1 = a; wdata1 = d;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive_port(0, 1'b0, 1'b0, '0, '0);
    drive_port(1, 1'b0, 1'b0, '0, '0);
    req0_f = 1'b0; req1_f = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  // One request on the round-robin instance; latency counts clock edges from
  // the cycle the request is raised (0 = no ack within the budget).
  task automatic txn(input int p, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                     output int lat, output logic e, output logic [DW-1:0] rd,
                     output int wecnt, output logic [AW-1:0] wa);
    int guard;
    guard = 0;
    while (busy && guard < 10) begin
      step();
      guard++;
    end
    drive_port(p, 1'b1, w, a, d);
    lat = 0; e = 1'b0; rd = '0; wecnt = 0; wa = '0;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (dm_we) begin
        wecnt++;
        wa = dm_addr;
      end
      if ((p == 0) ? ack0 : ack1) begin
        lat = i;
        e   = (p == 0) ? err0 : err1;
        rd  = (p == 0) ? rdata0 : rdata1;
        break;
      end
    end
    drive_port(p, 1'b0, w, a, d);
    if (p == 0 ? err0 : err1) begin
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive_port(0, 1'b1, 1'b1, 10'h010, 32'hCAFEF00D);
    step();
    step();
    vectors++;
    if ({ack0, ack1, err0, err1, busy, dm_we} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b expected 000000", {ack0, ack1, err0, err1, busy, dm_we});
    end
    vectors++;
    if (rdata0 !== '0 || rdata1 !== '0) begin
      miscompares++;
      $display("FAIL reset_rdata: got %h/%h expected 0/0", rdata0, rdata1);
    end
    vectors++;
    if (dm_addr !== '0 || dm_din !== '0) begin
      miscompares++;
      $display("FAIL reset_bus: got addr %h din %h expected 0/0", dm_addr, dm_din);
    end
    vectors++;
    if ({busy_f, ack0_f, ack1_f, dm_we_f} !== 4'b0) begin
      miscompares++;
      $display("FAIL reset_fp: got %b expected 0000", {busy_f, ack0_f, ack1_f, dm_we_f});
    end
    drive_port(0, 1'b0, 1'b0, '0, '0);
    reset = 1'b0;
    step();
  endtask

  task automatic test_write_read();
    int lat, wc; logic e; logic [DW-1:0] rd; logic [AW-1:0] wa;
    txn(0, 1'b1, 10'h010, 32'hDEADBEEF, lat, e, rd, wc, wa);
    ref_mem[4] = 32'hDEADBEEF;
    vectors++;
    if (lat !== 2) begin miscompares++; $display("FAIL wr_latency: got %0d expected 2", lat); end
    vectors++;
    if (e !== 1'b0 || rd !== '0) begin miscompares++; $display("FAIL wr_resp: got err %b rdata %h expected 0/0", e, rd); end
    vectors++;
    if (wc !== 1 || wa !== 10'h010) begin miscompares++; $display("FAIL wr_dm_we: got %0d pulses at %h expected 1 at 010", wc, wa); end
    txn(0, 1'b0, 10'h010, 32'h0, lat, e, rd, wc, wa);
    vectors++;
    if (lat !== 2) begin miscompares++; $display("FAIL rd_latency: got %0d expected 2", lat); end
    vectors++;
    if (rd !== ref_mem[4] || e !== 1'b0) begin miscompares++; $display("FAIL rd_data: got %h err %b expected %h err 0", rd, e, ref_mem[4]); end
    vectors++;
    if (wc !== 0) begin miscompares++; $display("FAIL rd_dm_we: got %0d pulses expected 0", wc); end
  endtask

  task automatic test_misaligned();
    int lat, wc; logic e; logic [DW-1:0] rd; logic [AW-1:0] wa;
    txn(1, 1'b0, 10'h006, 32'h0, lat, e, rd, wc, wa);
    vectors++;
    if (lat !== 1 || e !== 1'b1) begin miscompares++; $display("FAIL mis_rd_resp: got lat %0d err %b expected 1/1", lat, e); end
    vectors++;
    if (rd !== '0 || wc !== 0) begin miscompares++; $display("FAIL mis_rd_side: got rdata %h pulses %0d expected 0/0", rd, wc); end
    txn(1, 1'b1, 10'h006, 32'hAAAA5555, lat, e, rd, wc, wa);
    vectors++;
    if (lat !== 1 || e !== 1'b1 || wc !== 0) begin miscompares++; $display("FAIL mis_wr: got lat %0d err %b pulses %0d expected 1/1/0", lat, e, wc); end
    txn(0, 1'b0, 10'h004, 32'h0, lat, e, rd, wc, wa);
    vectors++;
    if (rd !== ref_mem[1] || e !== 1'b0) begin miscompares++; $display("FAIL mis_mem_intact: got %h expected %h", rd, ref_mem[1]); end
  endtask

  task automatic test_top_word();
    int lat, wc; logic e; logic [DW-1:0] rd; logic [AW-1:0] wa;
    txn(1, 1'b1, 10'h3FC, 32'h12345678, lat, e, rd, wc, wa);
    ref_mem[255] = 32'h12345678;
    vectors++;
    if (lat !== 2 || e !== 1'b0 || wc !== 1) begin miscompares++; $display("FAIL top_wr: got lat %0d err %b pulses %0d expected 2/0/1", lat, e, wc); end
    txn(0, 1'b0, 10'h3FC, 32'h0, lat, e, rd, wc, wa);
    vectors++;
    if (rd !== ref_mem[255]) begin miscompares++; $display("FAIL top_rd: got %h expected %h", rd, ref_mem[255]); end
    txn(0, 1'b0, 10'h000, 32'h0, lat, e, rd, wc, wa);
    vectors++;
    if (rd !== ref_mem[0]) begin miscompares++; $display("FAIL top_no_wrap: got %h expected %h", rd, ref_mem[0]); end
  endtask

  task automatic test_reset_abort();
    int lat, wc, acks, guard; logic e; logic [DW-1:0] rd; logic [AW-1:0] wa;
    guard = 0;
    while (busy && guard < 10) begin step(); guard++; end
    drive_port(0, 1'b1, 1'b1, 10'h020, 32'hFFFFFFFF);
    step();
    vectors++;
    if (dm_we !== 1'b1) begin miscompares++; $display("FAIL abort_in_access: got dm_we %b expected 1", dm_we); end
    reset = 1'b1;
    #1;
    vectors++;
    if (dm_we !== 1'b0) begin miscompares++; $display("FAIL abort_we_gated: got dm_we %b expected 0", dm_we); end
    drive_port(0, 1'b0, 1'b0, '0, '0);
    step();
    reset = 1'b0;
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL abort_idle: got busy %b expected 0", busy); end
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (ack0 || ack1) acks++;
    end
    vectors++;
    if (acks !== 0) begin miscompares++; $display("FAIL abort_no_ack: got %0d acks expected 0", acks); end
    txn(1, 1'b0, 10'h020, 32'h0, lat, e, rd, wc, wa);
    vectors++;
    if (rd !== ref_mem[8]) begin miscompares++; $display("FAIL abort_mem: got %h expected %h", rd, ref_mem[8]); end
  endtask

  task automatic test_round_robin();
    int lat, wc, t0, t1; logic e; logic [DW-1:0] rd, r0, r1; logic [AW-1:0] wa;
    txn(0, 1'b1, 10'h000, 32'h11111111, lat, e, rd, wc, wa);
    ref_mem[0] = 32'h11111111;
    txn(1, 1'b1, 10'h004, 32'h22222222, lat, e, rd, wc, wa);
    ref_mem[1] = 32'h22222222;
    do_reset();
    drive_port(0, 1'b1, 1'b0, 10'h000, '0);
    drive_port(1, 1'b1, 1'b0, 10'h004, '0);
    t0 = 0; t1 = 0; r0 = '0; r1 = '0;
    for (int c = 1; c <= 8; c++) begin
      step();
      if (ack0 && t0 == 0) begin t0 = c; r0 = rdata0; req0 = 1'b0; end
      if (ack1 && t1 == 0) begin t1 = c; r1 = rdata1; req1 = 1'b0; end
    end
    vectors++;
    if (t0 !== 2 || t1 !== 5) begin miscompares++; $display("FAIL rr_timing: got ack0@%0d ack1@%0d expected 2/5", t0, t1); end
    vectors++;
    if (r0 !== ref_mem[0]) begin miscompares++; $display("FAIL rr_rdata0: got %h expected %h", r0, ref_mem[0]); end
    vectors++;
    if (r1 !== ref_mem[1]) begin miscompares++; $display("FAIL rr_rdata1: got %h expected %h", r1, ref_mem[1]); end
  endtask

  // Both ports keep requesting random accesses back to back. The model:
  // a grant happens in the idle cycle after each completion; when both ports
  // have work they alternate starting from port 0, otherwise the one with work
  // goes; completion is 2 cycles after the grant (1 if misaligned).
  task automatic test_random_dual();
    logic           op_we [2][NRND];
    logic [AW-1:0]  op_a  [2][NRND];
    logic [DW-1:0]  op_d  [2][NRND];
    int             idx [2];
    int             ptr_m, t_idle, exp_p, exp_t, cyc, wecnt, exp_wecnt, w, off;
    logic [1:0]     exp_ack;
    logic           exp_e, got_e;
    logic [DW-1:0]  exp_rd, got_rd;
    logic [AW-1:0]  a;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < NRND; i++) begin
        w   = ($urandom_range(0, 7) == 0) ? 255 : int'($urandom_range(0, 15));
        off = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : 0;
        op_a[p][i]  = AW'(w * 4 + off);
        op_we[p][i] = 1'($urandom_range(0, 1));
        op_d[p][i]  = $urandom();
      end
    end
    do_reset();
    idx[0] = 0; idx[1] = 0;
    ptr_m = 0; t_idle = 0; cyc = 0; wecnt = 0; exp_wecnt = 0;
    drive_port(0, 1'b1, op_we[0][0], op_a[0][0], op_d[0][0]);
    drive_port(1, 1'b1, op_we[1][0], op_a[1][0], op_d[1][0]);
    exp_p = ptr_m;
    exp_t = t_idle + ((op_a[exp_p][0][1:0] == 2'b00) ? 2 : 1);
    while ((idx[0] < NRND || idx[1] < NRND) && cyc < 6 * NRND + 20) begin
      step();
      cyc++;
      if (dm_we) wecnt++;
      exp_ack = (cyc == exp_t) ? ((exp_p == 0) ? 2'b01 : 2'b10) : 2'b00;
      vectors++;
      if ({ack1, ack0} !== exp_ack) begin
        miscompares++;
        $display("FAIL rnd_ack cyc %0d: got %b expected %b", cyc, {ack1, ack0}, exp_ack);
      end
      if (cyc == exp_t) begin
        a      = op_a[exp_p][idx[exp_p]];
        exp_e  = (a[1:0] != 2'b00);
        exp_rd = (exp_e || op_we[exp_p][idx[exp_p]]) ? '0 : ref_mem[a[AW-1:2]];
        if (!exp_e && op_we[exp_p][idx[exp_p]]) begin
          ref_mem[a[AW-1:2]] = op_d[exp_p][idx[exp_p]];
          exp_wecnt++;
        end
        got_e  = (exp_p == 0) ? err0 : err1;
        got_rd = (exp_p == 0) ? rdata0 : rdata1;
        vectors++;
        if (got_e !== exp_e || got_rd !== exp_rd) begin
          miscompares++;
          $display("FAIL rnd_resp port %0d addr %h: got err %b rdata %h expected err %b rdata %h",
                   exp_p, a, got_e, got_rd, exp_e, exp_rd);
        end
        idx[exp_p]++;
        if (idx[exp_p] < NRND)
          drive_port(exp_p, 1'b1, op_we[exp_p][idx[exp_p]], op_a[exp_p][idx[exp_p]], op_d[exp_p][idx[exp_p]]);
        else
          drive_port(exp_p, 1'b0, 1'b0, '0, '0);
        ptr_m  = 1 - exp_p;
        t_idle = cyc + 1;
        if (idx[0] < NRND && idx[1] < NRND) exp_p = ptr_m;
        else if (idx[0] < NRND) exp_p = 0;
        else exp_p = 1;
        if (idx[exp_p] < NRND)
          exp_t = t_idle + ((op_a[exp_p][idx[exp_p]][1:0] == 2'b00) ? 2 : 1);
      end
    end
    vectors++;
    if (idx[0] < NRND || idx[1] < NRND) begin
      miscompares++;
      $display("FAIL rnd_timeout: got %0d/%0d done expected %0d/%0d", idx[0], idx[1], NRND, NRND);
    end
    vectors++;
    if (wecnt !== exp_wecnt) begin
      miscompares++;
      $display("FAIL rnd_write_count: got %0d dm_we cycles expected %0d", wecnt, exp_wecnt);
    end
    drive_port(0, 1'b0, 1'b0, '0, '0);
    drive_port(1, 1'b0, 1'b0, '0, '0);
    step();
    step();
  endtask

  task automatic test_fixed_prio();
    int t1, n0;
    logic [1:0] exp_ack;
    do_reset();
    req1_f = 1'b1; we1_f = 1'b1; addr1_f = 10'h004; wdata1_f = 32'h0BADF00D;
    req0_f = 1'b0; we0_f = 1'b0; addr0_f = '0; wdata0_f = '0;
    t1 = 0;
    for (int c = 1; c <= 6 && t1 == 0; c++) begin
      step();
      if (ack1_f) begin t1 = c; req1_f = 1'b0; end
    end
    vectors++;
    if (t1 !== 2) begin miscompares++; $display("FAIL fp_setup_wr: got ack1@%0d expected 2", t1); end
    step();
    req0_f = 1'b1; we0_f = 1'b0; addr0_f = 10'h000;
    req1_f = 1'b1; we1_f = 1'b0; addr1_f = 10'h004;
    n0 = 0;
    for (int c = 1; c <= 14; c++) begin
      step();
      exp_ack = 2'b00;
      if (c == 2 || c == 5 || c == 8) exp_ack = 2'b01;
      if (c == 11) exp_ack = 2'b10;
      vectors++;
      if ({ack1_f, ack0_f} !== exp_ack) begin
        miscompares++;
        $display("FAIL fp_ack cyc %0d: got %b expected %b", c, {ack1_f, ack0_f}, exp_ack);
      end
      if (ack0_f) begin
        n0++;
        if (n0 == 3) req0_f = 1'b0;
      end
      if (ack1_f) begin
        vectors++;
        if (rdata1_f !== 32'h0BADF00D) begin
          miscompares++;
          $display("FAIL fp_rdata1: got %h expected 0badf00d", rdata1_f);
        end
        req1_f = 1'b0;
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    req0_f = 1'b0; req1_f = 1'b0; we0_f = 1'b0; we1_f = 1'b0;
    addr0_f = '0; addr1_f = '0; wdata0_f = '0; wdata1_f = '0;
    for (int i = 0; i < 1024; i++) begin
      mem[i]   = 8'h00;
      mem_f[i] = 8'h00;
    end
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
    test_reset();
    test_write_read();
    test_misaligned();
    test_top_word();
    test_reset_abort();
    test_round_robin();
    test_random_dual();
    test_fixed_prio();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
